// File: rtl/alu_normalize_seq.sv
// Iterative left-normalizer: shifts an operand left one bit per cycle until it is
// left-justified (unsigned) or has a single sign bit (signed). It reports the shift count.
module alu_normalize_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_shamt,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   w_q, w_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   shamt_q, shamt_d;
    logic               zero_q, zero_d;

    logic               w_is_zero;
    logic               justified;

    assign w_is_zero = (w_q == '0);

    // A signed operand is normalized once its top two bits differ. The count cap
    // stops all-ones (-1), whose top bits never differ.
    always_comb begin
        if (sgn_q) begin
            justified = (w_q[WIDTH-1] != w_q[WIDTH-2]) || (cnt_q == CNT_MAX);
        end else begin
            justified = w_q[WIDTH-1];
        end
    end

    // NOTE: every signal driven here gets a hold-value default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    w_d     = in_data;
                    sgn_d   = in_signed;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                if (w_is_zero) begin
                    state_d = DONE;
                    data_d  = '0;
                    shamt_d = '0;
                    zero_d  = 1'b1;
                end else if (justified) begin
                    state_d = DONE;
                    data_d  = w_q;
                    shamt_d = cnt_q;
                    zero_d  = 1'b0;
                end else begin
                    w_d   = w_q << 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values. Reset is synchronous, so it is sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            zero_q  <= zero_d;
        end
    end

    // in_ready is gated by rst_n so no operand looks accepted while reset is asserted.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_alu_normalize_seq.sv
// Directed and random checks of alu_normalize_seq. The bench covers reset, normalization results,
// latency, backpressure and reset in mid-operation. Expected results go through a scoreboard queue.
module tb_alu_normalize_seq;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_shamt;
    logic             out_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] shamt;
        logic             zero;
    } exp_t;

    exp_t sb[$];

    alu_normalize_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shamt (out_shamt),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count redundant leading bits directly from the operand.
    task automatic norm_model(input logic [WIDTH-1:0] d, input logic s, output exp_t e);
        int k;
        k = 0;
        if (d == '0) begin
            e.data = '0; e.shamt = '0; e.zero = 1'b1;
        end else begin
            if (s) begin
                for (int i = WIDTH - 2; i >= 0; i--) begin
                    if (d[i] != d[WIDTH-1]) break;
                    k++;
                end
            end else begin
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (d[i]) break;
                    k++;
                end
            end
            e.data = d << k; e.shamt = CNT_W'(k); e.zero = 1'b0;
        end
    endtask

    // One full transaction. It holds in_valid high with junk while busy and applies `hold` cycles of backpressure.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input logic s,
                          input logic [WIDTH-1:0] ed, input logic [CNT_W-1:0] es,
                          input logic ez, input int hold);
        exp_t e;
        exp_t got;
        int   t;
        int   lat;
        logic [WIDTH-1:0] snap_d;
        logic [CNT_W-1:0] snap_s;
        logic             snap_z;
        e.data = ed; e.shamt = es; e.zero = ez;
        sb.push_back(e);

        t = 0;
        while (!in_ready && t < 40) begin tick(); t++; end
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);

        in_valid = 1'b1; in_data = d; in_signed = s; out_ready = 1'b0;
        tick();
        in_data = ~d; in_signed = ~s;
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);

        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        in_valid = 1'b0;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(es) + 32'd1);

        snap_d = out_data; snap_s = out_shamt; snap_z = out_zero;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_stable"}, {11'd0, snap_z, snap_s, snap_d},
                  {11'd0, out_zero, out_shamt, out_data});
        end

        got = sb.pop_front();
        check({tag, "_data"}, 32'(out_data), 32'(got.data));
        check({tag, "_shamt"}, 32'(out_shamt), 32'(got.shamt));
        check({tag, "_zero"}, 32'(out_zero), 32'(got.zero));

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        exp_t m;
        logic [WIDTH-1:0] rd;
        logic             rs;
        int               seen;

        rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", {11'd0, out_zero, out_shamt, out_data}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("first_idle_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("idle_out_ready_noeffect", 32'(out_valid), 32'd0);

        run_op("u0001", 16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0, 0);
        run_op("u8000", 16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0, 0);
        run_op("s8000", 16'h8000, 1'b1, 16'h8000, 4'd0,  1'b0, 0);
        run_op("s0003", 16'h0003, 1'b1, 16'h6000, 4'd13, 1'b0, 0);
        run_op("sFFFF", 16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0, 0);
        run_op("sFFF0", 16'hFFF0, 1'b1, 16'h8000, 4'd11, 1'b0, 0);
        run_op("u0000", 16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1, 0);
        run_op("s0000", 16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1, 0);
        run_op("u0003", 16'h0003, 1'b0, 16'hC000, 4'd14, 1'b0, 0);
        run_op("s4000", 16'h4000, 1'b1, 16'h4000, 4'd0,  1'b0, 0);
        run_op("sC000", 16'hC000, 1'b1, 16'h8000, 4'd1,  1'b0, 0);
        run_op("bp_u0010", 16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0, 5);

        in_valid = 1'b1; in_data = 16'h0001; in_signed = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", {11'd0, out_zero, out_shamt, out_data}, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_op("post_rst_u0100", 16'h0100, 1'b0, 16'h8000, 4'd7, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            rd = 16'($urandom);
            if (i % 3 == 0) rd = rd >> $urandom_range(4, 14);
            rs = 1'($urandom_range(0, 1));
            norm_model(rd, rs, m);
            run_op($sformatf("rnd%0d", i), rd, rs, m.data, m.shamt, m.zero, i % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
